// File: rtl/fb_pkg.sv
// Framebuffer geometry shared by the renderer, this store and the linebuffer.
package fb_pkg;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 180;
    localparam int DATAW     = 8;
    localparam int CORDW     = 16;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int ADDRW     = $clog2(FB_PIXELS);
endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: two-flop synchroniser, stability counter and
// registered press/release pulses.
module btn_debounce #(
    parameter int DEB_CNTW = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_out,
    output logic btn_ondn,
    output logic btn_onup
);
    logic [1:0]          sync_q;
    logic [DEB_CNTW-1:0] cnt_q, cnt_d;
    logic                out_q, out_d;
    logic                ondn_q, onup_q;

    // The counter only advances while the synced level disagrees with the output.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (sync_q[1] != out_q) begin
            if (cnt_q == {DEB_CNTW{1'b1}}) begin
                out_d = sync_q[1];
                cnt_d = {DEB_CNTW{1'b0}};
            end else begin
                cnt_d = cnt_q + DEB_CNTW'(1);
            end
        end else begin
            cnt_d = {DEB_CNTW{1'b0}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            cnt_q  <= {DEB_CNTW{1'b0}};
            out_q  <= 1'b0;
            ondn_q <= 1'b0;
            onup_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_in};
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            ondn_q <= out_d & ~out_q;
            onup_q <= ~out_d & out_q;
        end
    end

    assign btn_out  = out_q;
    assign btn_ondn = ondn_q;
    assign btn_onup = onup_q;
endmodule

// File: rtl/fb_write_store.sv
// Framebuffer store: button debounce, 3-stage clipped address pipeline and
// simple-dual-port pixel memory with a registered read port.
module fb_write_store #(
    parameter int    CORDW     = fb_pkg::CORDW,
    parameter int    DATAW     = fb_pkg::DATAW,
    parameter int    FB_WIDTH  = fb_pkg::FB_WIDTH,
    parameter int    FB_HEIGHT = fb_pkg::FB_HEIGHT,
    parameter int    DEPTH     = FB_WIDTH * FB_HEIGHT,
    parameter int    ADDRW     = $clog2(DEPTH),
    parameter int    NBTN      = 3,
    parameter int    DEB_CNTW  = 16,
    parameter string INIT_F    = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NBTN-1:0]         btn_in,
    output logic [NBTN-1:0]         btn_out,
    output logic [NBTN-1:0]         btn_ondn,
    output logic [NBTN-1:0]         btn_onup,
    input  logic                    draw,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic signed [CORDW-1:0] offx,
    input  logic signed [CORDW-1:0] offy,
    input  logic [DATAW-1:0]        colr_in,
    input  logic [ADDRW-1:0]        rd_addr,
    output logic [DATAW-1:0]        rd_data,
    output logic                    wr_en,
    output logic [ADDRW-1:0]        wr_addr,
    output logic                    clip
);
    localparam logic signed [CORDW-1:0] W_S = CORDW'(FB_WIDTH);
    localparam logic signed [CORDW-1:0] H_S = CORDW'(FB_HEIGHT);

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_debounce #(.DEB_CNTW(DEB_CNTW)) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_in   (btn_in[i]),
            .btn_out  (btn_out[i]),
            .btn_ondn (btn_ondn[i]),
            .btn_onup (btn_onup[i])
        );
    end

    logic                    v1_q, v2_q, wr_en_q, clip2_q, clip_q;
    logic signed [CORDW-1:0] xo_q, yo_q, xo2_q, xo_d, yo_d;
    logic [DATAW-1:0]        colr1_q, colr2_q, colr3_q;
    logic [ADDRW-1:0]        prod_q, prod_d, wr_addr_q, wr_addr_d;
    logic                    clip_d;
    logic [DATAW-1:0]        rd_data_q;

    // Negative coordinates show up as a set sign bit after the offset add.
    always_comb begin
        xo_d      = x + offx;
        yo_d      = y + offy;
        clip_d    = xo_q[CORDW-1] | (xo_q >= W_S) | yo_q[CORDW-1] | (yo_q >= H_S);
        prod_d    = ADDRW'(int'(yo_q) * FB_WIDTH);
        wr_addr_d = prod_q + ADDRW'(xo2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            clip_q    <= 1'b0;
            clip2_q   <= 1'b0;
            xo_q      <= {CORDW{1'b0}};
            yo_q      <= {CORDW{1'b0}};
            xo2_q     <= {CORDW{1'b0}};
            prod_q    <= {ADDRW{1'b0}};
            wr_addr_q <= {ADDRW{1'b0}};
            colr1_q   <= {DATAW{1'b0}};
            colr2_q   <= {DATAW{1'b0}};
            colr3_q   <= {DATAW{1'b0}};
        end else begin
            v1_q      <= draw;
            xo_q      <= xo_d;
            yo_q      <= yo_d;
            colr1_q   <= colr_in;
            v2_q      <= v1_q;
            clip2_q   <= clip_d;
            prod_q    <= prod_d;
            xo2_q     <= xo_q;
            colr2_q   <= colr1_q;
            wr_en_q   <= v2_q & ~clip2_q;
            clip_q    <= v2_q & clip2_q;
            wr_addr_q <= wr_addr_d;
            colr3_q   <= colr2_q;
        end
    end

    // Pixel contents deliberately survive reset.
    logic [DATAW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_q) begin
            mem[wr_addr_q] <= colr3_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= {DATAW{1'b0}};
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign clip    = clip_q;
endmodule

// File: tb/tb_fb_write_store.sv
// Scoreboarded bench for fb_write_store with a coordinate-level reference model.
module tb_fb_write_store;
    localparam int CORDW = 16;
    localparam int DATAW = 8;
    localparam int W     = 320;
    localparam int H     = 180;
    localparam int ADDRW = 16;
    localparam int NBTN  = 3;
    localparam int DEBW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic [NBTN-1:0]         btn_in, btn_out, btn_ondn, btn_onup;
    logic                    draw;
    logic signed [CORDW-1:0] x, y, offx, offy;
    logic [DATAW-1:0]        colr_in, rd_data;
    logic [ADDRW-1:0]        rd_addr, wr_addr;
    logic                    wr_en, clip;

    fb_write_store #(
        .CORDW(CORDW), .DATAW(DATAW), .FB_WIDTH(W), .FB_HEIGHT(H),
        .NBTN(NBTN), .DEB_CNTW(DEBW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_out(btn_out),
        .btn_ondn(btn_ondn), .btn_onup(btn_onup), .draw(draw), .x(x), .y(y),
        .offx(offx), .offy(offy), .colr_in(colr_in), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .clip(clip)
    );

    typedef struct {int cyc; bit clp; int addr; int colr;} exp_t;
    exp_t sb[$];
    int   mem_model[int];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ox = 0;
    int   oy = 0;
    int   dn_cnt[NBTN];
    int   up_cnt[NBTN];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < NBTN; i++) begin
            dn_cnt[i] <= dn_cnt[i] + int'(btn_ondn[i]);
            up_cnt[i] <= up_cnt[i] + int'(btn_onup[i]);
        end
    end

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Reference: offset, clip against the bitmap, row-major address.
    task automatic issue(input bit d, input int xv, input int yv, input int cv);
        logic signed [15:0] xs, ys;
        int xo, yo;
        exp_t e;
        @(negedge clk);
        draw = d; x = 16'(xv); y = 16'(yv); colr_in = 8'(cv);
        if (d) begin
            xs = 16'(xv + ox); ys = 16'(yv + oy);
            xo = int'(xs); yo = int'(ys);
            e.cyc  = cyc + 3;
            e.clp  = (xo < 0) || (xo >= W) || (yo < 0) || (yo >= H);
            e.addr = e.clp ? 0 : yo * W + xo;
            e.colr = cv & 255;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        repeat (5) issue(1'b0, 0, 0, 0);
    endtask

    task automatic set_off(input int a, input int b);
        ox = a; oy = b; offx = 16'(a); offy = 16'(b);
    endtask

    task automatic rd_check(input string nm, input int a);
        @(negedge clk);
        draw = 1'b0; rd_addr = 16'(a);
        @(negedge clk);
        check(nm, int'(rd_data), mem_model.exists(a) ? mem_model[a] : -1);
    endtask

    // Monitor: pop on every presented output, flag outputs that never came.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    checks++; errors++;
                    $display("FAIL sb_missing: no output at cycle %0d, want addr=%0d clip=%0d", e.cyc, e.addr, e.clp);
                end
                if (wr_en || clip) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got wr_en=%0d clip=%0d addr=%0d at cycle %0d, want nothing", wr_en, clip, wr_addr, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (cyc != e.cyc || clip != e.clp || wr_en == e.clp ||
                            (!e.clp && int'(wr_addr) != e.addr)) begin
                            errors++;
                            $display("FAIL sb_pixel: got cyc=%0d wr_en=%0d clip=%0d addr=%0d want cyc=%0d clip=%0d addr=%0d",
                                     cyc, wr_en, clip, wr_addr, e.cyc, e.clp, e.addr);
                        end
                        if (!e.clp) mem_model[e.addr] = e.colr;
                    end
                end
            end
        end
    end

    initial begin
        int v0, n;
        int keys[$];
        rst_n = 1'b0; btn_in = '0; draw = 1'b0; x = '0; y = '0;
        colr_in = '0; rd_addr = '0;
        set_off(0, 0);
        for (int i = 0; i < NBTN; i++) begin dn_cnt[i] = 0; up_cnt[i] = 0; end
        repeat (3) @(negedge clk);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_clip", int'(clip), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_btn_out", int'(btn_out), 0);
        check("rst_btn_pulses", int'(btn_ondn | btn_onup), 0);
        rst_n = 1'b1;

        // Origin, corner, offset address and clip preload values.
        issue(1'b1, 0, 0, 'h5A);
        issue(1'b1, 0, 5, 'h33);
        issue(1'b1, W - 1, H - 1, 'h77);
        drain();
        rd_check("origin_rd", 0);
        check("corner_addr_model", mem_model.exists(57599) ? 1 : 0, 1);
        rd_check("corner_rd", 57599);
        set_off(5, 1);
        issue(1'b1, 10, 2, 'h42);
        drain();
        set_off(0, 0);
        check("offset_addr_model", mem_model.exists(975) ? 1 : 0, 1);
        rd_check("offset_rd", 975);

        // Clipped draws must leave memory untouched.
        issue(1'b1, W, 0, 'hEE);
        issue(1'b1, -1, 5, 'hEE);
        issue(1'b1, 0, H, 'hEE);
        drain();
        rd_check("clip_rd0", 0);
        rd_check("clip_rd1600", 1600);

        // Same-cycle read and write of one address returns the old word.
        v0 = mem_model[0];
        rd_addr = '0;
        issue(1'b1, 0, 0, 'hA5);
        repeat (4) issue(1'b0, 0, 0, 0);
        check("rdw_old", int'(rd_data), v0);
        issue(1'b0, 0, 0, 0);
        check("rdw_new", int'(rd_data), 'hA5);

        for (int i = 0; i < W; i++) issue(1'b1, i, 7, i ^ 7);
        drain();
        rd_check("stream_rd_first", 2240);
        rd_check("stream_rd_last", 2559);

        set_off(int'($urandom_range(16)) - 8, int'($urandom_range(16)) - 8);
        for (int i = 0; i < 300; i++)
            issue($urandom_range(3) != 0, int'($urandom_range(379)) - 30,
                  int'($urandom_range(209)) - 15, int'($urandom_range(255)));
        drain();
        set_off(0, 0);
        foreach (mem_model[k]) keys.push_back(k);
        n = 0;
        for (int i = 0; i < keys.size() && n < 30; i += 7) begin
            rd_check("rand_rd", keys[i]);
            n++;
        end

        // Debounce: short glitch, random glitches, long press and release.
        btn_in[0] = 1'b1; repeat (10) @(negedge clk);
        btn_in[0] = 1'b0; repeat (30) @(negedge clk);
        check("deb_glitch_out", int'(btn_out[0]), 0);
        check("deb_glitch_dn", dn_cnt[0], 0);
        repeat (5) begin
            btn_in[2] = 1'b1; repeat ($urandom_range(12, 1)) @(negedge clk);
            btn_in[2] = 1'b0; repeat (5) @(negedge clk);
        end
        check("deb_rand_glitch", int'(btn_out[2]) + dn_cnt[2] + up_cnt[2], 0);
        btn_in[1] = 1'b1; repeat (40) @(negedge clk);
        check("deb_press_out", int'(btn_out), 2);
        check("deb_press_dn", dn_cnt[1], 1);
        btn_in[1] = 1'b0; repeat (40) @(negedge clk);
        check("deb_release_out", int'(btn_out), 0);
        check("deb_release_up", up_cnt[1], 1);
        check("deb_release_dn", dn_cnt[1], 1);

        // Reset mid-stream drops in-flight pixels but keeps memory.
        for (int i = 0; i < 10; i++) issue(1'b1, i, 20, 'h10 + i);
        @(posedge clk);
        #1;
        rst_n = 1'b0; draw = 1'b0;
        sb.delete();
        #1;
        check("midrst_wr_en", int'(wr_en), 0);
        check("midrst_clip", int'(clip), 0);
        check("midrst_wr_addr", int'(wr_addr), 0);
        check("midrst_rd_data", int'(rd_data), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 0, 0, 0);
            check("post_rst_wr_en", int'(wr_en), 0);
        end
        issue(1'b1, 50, 20, 'h99);
        drain();
        rd_check("post_rst_new", 20 * W + 50);
        rd_check("retain_row20", 20 * W);
        rd_check("retain_origin", 0);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
